// File: rtl/cnn_acc_pkg.sv
// Shared types and constants for the conv accelerator control path.
package cnn_acc_pkg;

    localparam int CH_GRP_W     = 2;
    localparam int CH_GRP_SCALE = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_LOAD,
        ST_FIRE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } sched_state_e;

endpackage

// File: rtl/tile_idx_ctr.sv
// Nested row-tile / output-channel-group counter. The tile index wraps at
// i_max_tile and carries into the group index.
module tile_idx_ctr
    import cnn_acc_pkg::*;
#(
    parameter int TILE_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_clr,
    input  logic                i_inc,
    input  logic [TILE_W-1:0]   i_max_tile,
    input  logic [CH_GRP_W-1:0] i_max_grp,
    output logic [TILE_W-1:0]   o_tile,
    output logic [CH_GRP_W-1:0] o_grp,
    output logic                o_last
);

    logic [TILE_W-1:0]   r_tile;
    logic [CH_GRP_W-1:0] r_grp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tile <= '0;
            r_grp  <= '0;
        end else if (i_clr) begin
            r_tile <= '0;
            r_grp  <= '0;
        end else if (i_inc) begin
            if (r_tile == i_max_tile) begin
                r_tile <= '0;
                r_grp  <= r_grp + CH_GRP_W'(1);
            end else begin
                r_tile <= r_tile + TILE_W'(1);
            end
        end
    end

    assign o_tile = r_tile;
    assign o_grp  = r_grp;
    assign o_last = (r_tile == i_max_tile) && (r_grp == i_max_grp);

endmodule

// File: rtl/conv_tile_scheduler.sv
// Layer sequencer for the 3x3 conv PE array: config pulse, per-tile preload,
// PE pass trigger, pipeline drain and layer completion with a pass timeout.
module conv_tile_scheduler
    import cnn_acc_pkg::*;
#(
    parameter int TILE_W      = 5,
    parameter int DRAIN_CYC   = 4,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [CH_GRP_W-1:0] i_cfg_ci,
    input  logic [CH_GRP_W-1:0] i_cfg_co,
    input  logic [TILE_W-1:0]   i_cfg_tiles,
    output logic                o_ld_req,
    input  logic                i_ld_ack,
    output logic [TILE_W-1:0]   o_ld_tile_idx,
    output logic [CH_GRP_W-1:0] o_ld_co_grp,
    output logic                o_pe_start_conv,
    output logic [CH_GRP_W-1:0] o_pe_cfg_ci,
    output logic [CH_GRP_W-1:0] o_pe_cfg_co,
    output logic                o_pe_start_again,
    input  logic                i_pe_last_ch,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err
);

    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam int TMO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    sched_state_e        r_state;
    logic                r_ldReq;
    logic                r_startConv;
    logic                r_startAgain;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_lastPrev;
    logic                r_seenRise;
    logic [CH_GRP_W-1:0] r_cfgCi;
    logic [CH_GRP_W-1:0] r_cfgCo;
    logic [TILE_W-1:0]   r_cfgTiles;
    logic [DRAIN_W-1:0]  r_drain;
    logic [TMO_W-1:0]    r_tmo;

    logic                w_last;
    logic                w_rise;
    logic                w_fall;
    logic                w_drainEnd;
    logic                w_tmoHit;
    logic                w_ctrClr;
    logic                w_ctrInc;
    logic [TMO_W-1:0]    w_tmoNext;

    assign w_rise     = i_pe_last_ch & ~r_lastPrev;
    assign w_fall     = ~i_pe_last_ch & r_lastPrev;
    assign w_drainEnd = (r_drain == DRAIN_W'(DRAIN_CYC - 1));
    assign w_tmoNext  = r_tmo + TMO_W'(1);
    assign w_tmoHit   = (TIMEOUT_CYC != 0) && (w_tmoNext == TMO_W'(TIMEOUT_CYC));

    // Counter moves only on edges where the FSM below really takes the step.
    assign w_ctrClr = ~i_abort && (r_state == ST_IDLE) && i_start;
    assign w_ctrInc = ~i_abort && (r_state == ST_DRAIN) && w_drainEnd && ~w_last;

    tile_idx_ctr #(
        .TILE_W     (TILE_W)
    ) u_tileCtr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_ctrClr),
        .i_inc      (w_ctrInc),
        .i_max_tile (r_cfgTiles),
        .i_max_grp  (r_cfgCo),
        .o_tile     (o_ld_tile_idx),
        .o_grp      (o_ld_co_grp),
        .o_last     (w_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ldReq      <= 1'b0;
            r_startConv  <= 1'b0;
            r_startAgain <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_lastPrev   <= 1'b0;
            r_seenRise   <= 1'b0;
            r_cfgCi      <= '0;
            r_cfgCo      <= '0;
            r_cfgTiles   <= '0;
            r_drain      <= '0;
            r_tmo        <= '0;
        end else begin
            r_lastPrev   <= i_pe_last_ch;
            r_startConv  <= 1'b0;
            r_startAgain <= 1'b0;
            r_done       <= 1'b0;
            if (i_abort) begin
                r_state <= ST_IDLE;
                r_ldReq <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_cfgCi     <= i_cfg_ci;
                            r_cfgCo     <= i_cfg_co;
                            r_cfgTiles  <= i_cfg_tiles;
                            r_err       <= 1'b0;
                            r_busy      <= 1'b1;
                            r_startConv <= 1'b1;
                            r_state     <= ST_CFG;
                        end
                    end
                    ST_CFG: begin
                        r_ldReq <= 1'b1;
                        r_state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (i_ld_ack) begin
                            r_ldReq      <= 1'b0;
                            r_startAgain <= 1'b1;
                            r_state      <= ST_FIRE;
                        end
                    end
                    ST_FIRE: begin
                        r_tmo      <= '0;
                        r_seenRise <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                    // A pass ends on the falling edge of a burst whose rise was seen in RUN.
                    ST_RUN: begin
                        r_tmo <= w_tmoNext;
                        if (w_rise) begin
                            r_seenRise <= 1'b1;
                        end
                        if (r_seenRise && w_fall) begin
                            r_drain <= '0;
                            r_state <= ST_DRAIN;
                        end else if (w_tmoHit) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                    ST_DRAIN: begin
                        if (w_drainEnd) begin
                            if (w_last) begin
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end else begin
                                r_ldReq <= 1'b1;
                                r_state <= ST_LOAD;
                            end
                        end else begin
                            r_drain <= r_drain + DRAIN_W'(1);
                        end
                    end
                    ST_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_ld_req         = r_ldReq;
    assign o_pe_start_conv  = r_startConv;
    assign o_pe_start_again = r_startAgain;
    assign o_pe_cfg_ci      = r_cfgCi;
    assign o_pe_cfg_co      = r_cfgCo;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_err            = r_err;

endmodule
